// File: rtl/surf_command_receiver_v3_if.sv
`timescale 1ns/1ps
// Command-line input and decoded-output bundle for the SURF command receiver.
// The receiver is the master: it consumes cmd_i and drives every decoded output.
interface surf_command_receiver_v3_if #(
  parameter int NBUF     = 2,
  parameter int NID      = 32,
  parameter int ERR_BITS = 8
) ();
  logic                  cmd_i;
  logic [NID-1:0]        event_id_o;
  logic [NBUF-1:0]       event_id_buffer_o;
  logic                  event_id_wr_o;
  logic [(1<<NBUF)-1:0]  digitize_o;
  logic                  parity_err_o;
  logic                  frame_err_o;
  logic [ERR_BITS-1:0]   err_cnt_o;
  logic                  busy_o;
  logic                  sample_o;

  modport master (
    input  cmd_i,
    output event_id_o, event_id_buffer_o, event_id_wr_o, digitize_o,
           parity_err_o, frame_err_o, err_cnt_o, busy_o, sample_o
  );

  modport slave (
    output cmd_i,
    input  event_id_o, event_id_buffer_o, event_id_wr_o, digitize_o,
           parity_err_o, frame_err_o, err_cnt_o, busy_o, sample_o
  );
endinterface

// File: rtl/surf_command_receiver_v3.sv
`timescale 1ns/1ps
// Oversampling serial command receiver: start bit, buffer field, event-ID field,
// optional even parity, stop bit; commits ID/buffer and a one-hot digitize pulse.
module surf_command_receiver_v3 #(
  parameter int CLKS_PER_BIT = 8,
  parameter int START_WAIT   = 6,
  parameter int NBUF         = 2,
  parameter int NID          = 32,
  parameter int PARITY_EN    = 1,
  parameter int ERR_BITS     = 8
) (
  input  logic                        clk33_i,
  input  logic                        rst_n_i,
  surf_command_receiver_v3_if.master  bus
);

  localparam int CNT_MAX = (CLKS_PER_BIT > START_WAIT) ? CLKS_PER_BIT : START_WAIT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int FLD_MAX = (NID > NBUF) ? NID : NBUF;
  localparam int BW      = $clog2(FLD_MAX) + 1;
  localparam int NDIG    = 1 << NBUF;

  localparam logic [CW-1:0] WAIT_LAST = CW'(START_WAIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BUF_LAST  = BW'(NBUF - 1);
  localparam logic [BW-1:0] ID_LAST   = BW'(NID - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_BUF, S_ID, S_PAR, S_STOP, S_RECOVER
  } state_e;

  logic                iob_q, cmd_sync_q;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NBUF-1:0]     buf_sr_q, buf_sr_d;
  logic [NID-1:0]      id_sr_q, id_sr_d;
  logic                par_acc_q, par_acc_d;
  logic [NID-1:0]      event_id_q, event_id_d;
  logic [NBUF-1:0]     event_id_buffer_q, event_id_buffer_d;
  logic                event_id_wr_q, event_id_wr_d;
  logic [NDIG-1:0]     digitize_q, digitize_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic [ERR_BITS-1:0] err_cnt_q, err_cnt_d;
  logic                in_bit, sample;

  // NOTE: every variable gets a default before the case statement, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    bit_cnt_d         = bit_cnt_q;
    buf_sr_d          = buf_sr_q;
    id_sr_d           = id_sr_q;
    par_acc_d         = par_acc_q;
    event_id_d        = event_id_q;
    event_id_buffer_d = event_id_buffer_q;
    event_id_wr_d     = 1'b0;
    digitize_d        = '0;
    parity_err_d      = 1'b0;
    frame_err_d       = 1'b0;
    err_cnt_d         = err_cnt_q;

    in_bit = (state_q == S_BUF) || (state_q == S_ID) ||
             (state_q == S_PAR) || (state_q == S_STOP);
    sample = in_bit && (cnt_q == BIT_LAST);

    if (in_bit) begin
      cnt_d = sample ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_sync_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d   = S_BUF;
          cnt_d     = '0;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BUF: begin
        if (sample) begin
          // Shift right with the new bit entering the MSB: first bit lands in bit 0.
          buf_sr_d  = NBUF'({cmd_sync_q, buf_sr_q} >> 1);
          par_acc_d = par_acc_q ^ cmd_sync_q;
          if (bit_cnt_q == BUF_LAST) begin
            state_d   = S_ID;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_ID: begin
        if (sample) begin
          id_sr_d   = NID'({cmd_sync_q, id_sr_q} >> 1);
          par_acc_d = par_acc_q ^ cmd_sync_q;
          if (bit_cnt_q == ID_LAST) begin
            state_d   = (PARITY_EN != 0) ? S_PAR : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (sample) begin
          par_acc_d = par_acc_q ^ cmd_sync_q;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          state_d = S_RECOVER;
          // A framing error masks a simultaneous parity error.
          if (cmd_sync_q) begin
            frame_err_d = 1'b1;
          end else if ((PARITY_EN != 0) && par_acc_q) begin
            parity_err_d = 1'b1;
          end else begin
            event_id_d             = id_sr_q;
            event_id_buffer_d      = buf_sr_q;
            event_id_wr_d          = 1'b1;
            digitize_d[buf_sr_q]   = 1'b1;
          end
        end
      end
      S_RECOVER: begin
        // Wait for the line to go low so a stuck-high line cannot re-trigger.
        if (!cmd_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((frame_err_d || parity_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      iob_q             <= 1'b0;
      cmd_sync_q        <= 1'b0;
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      bit_cnt_q         <= '0;
      buf_sr_q          <= '0;
      id_sr_q           <= '0;
      par_acc_q         <= 1'b0;
      event_id_q        <= '0;
      event_id_buffer_q <= '0;
      event_id_wr_q     <= 1'b0;
      digitize_q        <= '0;
      parity_err_q      <= 1'b0;
      frame_err_q       <= 1'b0;
      err_cnt_q         <= '0;
    end else begin
      iob_q             <= bus.cmd_i;
      cmd_sync_q        <= iob_q;
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      bit_cnt_q         <= bit_cnt_d;
      buf_sr_q          <= buf_sr_d;
      id_sr_q           <= id_sr_d;
      par_acc_q         <= par_acc_d;
      event_id_q        <= event_id_d;
      event_id_buffer_q <= event_id_buffer_d;
      event_id_wr_q     <= event_id_wr_d;
      digitize_q        <= digitize_d;
      parity_err_q      <= parity_err_d;
      frame_err_q       <= frame_err_d;
      err_cnt_q         <= err_cnt_d;
    end
  end

  assign bus.event_id_o        = event_id_q;
  assign bus.event_id_buffer_o = event_id_buffer_q;
  assign bus.event_id_wr_o     = event_id_wr_q;
  assign bus.digitize_o        = digitize_q;
  assign bus.parity_err_o      = parity_err_q;
  assign bus.frame_err_o       = frame_err_q;
  assign bus.err_cnt_o         = err_cnt_q;
  assign bus.busy_o            = (state_q != S_IDLE);
  assign bus.sample_o          = sample;

endmodule

// File: doc/surf_command_receiver_v3.md
Name: surf_command_receiver_v3

Overview:
Parametrised next-generation serial command receiver for the SURF trigger/digitize link. It oversamples the single-wire command line at clk33_i, decodes framed commands, and produces the event ID and buffer number plus a one-hot digitize pulse. Compared with v2 it adds configurable bit period, buffer-field width and event-ID width, optional even parity, framing-error detection, stuck-high re-arm protection and a saturating error counter. It sits between the command input pin and the digitizer/readout control logic.

Parameters:
CLKS_PER_BIT, 8, clocks per command bit; must be ≥ 2.
START_WAIT, 6, clocks spent in WAIT after the start bit is detected, before the first bit period begins.
NBUF, 2, width of the buffer-number field; digitize width is 2**NBUF.
NID, 32, width of the event-ID field.
PARITY_EN, 1, 1 means an even-parity bit follows the ID field; 0 means no parity bit.
ERR_BITS, 8, width of the error counter.

Ports:
clk33_i  in  1  system clock; the sole clock.
rst_n_i  in  1  synchronous, active-low reset.
cmd_i  in  1  raw serial command line; captured in an IOB register.
event_id_o  out  NID  last received event ID.
event_id_buffer_o  out  NBUF  last received buffer number.
event_id_wr_o  out  1  one-cycle strobe: a valid frame was committed.
digitize_o  out  2**NBUF  one-hot one-cycle digitize pulse.
parity_err_o  out  1  one-cycle strobe: parity failed, frame dropped.
frame_err_o  out  1  one-cycle strobe: stop bit was 1, frame dropped.
err_cnt_o  out  ERR_BITS  saturating count of parity and framing errors.
busy_o  out  1  high whenever the FSM is not in IDLE.
sample_o  out  1  high on every bit-sample cycle, for debug.

Behaviour:
Synchronisation:
- cmd_i is registered into an IOB flop, then into a second flop, cmd_sync. All decisions use cmd_sync.
- Input latency is 2 cycles.

Reset (rst_n_i = 0 at a clock edge):
- FSM goes to IDLE and all counters clear.
- event_id_o = 0, event_id_buffer_o = 0, err_cnt_o = 0.
- All strobes, busy_o and sample_o are 0.
- A reset mid-frame discards the frame and produces no strobes.

FSM states: IDLE, WAIT, BUF, ID, PAR, STOP, RECOVER.
- IDLE: when cmd_sync = 1, go to WAIT and set the counter to 0.
- WAIT: the counter runs 0 to START_WAIT-1. On START_WAIT-1, go to BUF and set the counter to 0.
- Bit period, in BUF/ID/PAR/STOP: the counter runs 0 to CLKS_PER_BIT-1 and wraps. The sample cycle is counter = CLKS_PER_BIT-1, and sample_o is high on that cycle only.
- BUF: samples NBUF bits, LSB first, then goes to ID.
- ID: samples NID bits, shifting right with the new bit entering the MSB; the first received bit ends in bit 0.
- After ID: go to PAR if PARITY_EN = 1, otherwise go to STOP.
- PAR: samples one bit, then goes to STOP.
- STOP: samples one bit, then goes to RECOVER.
- Field bit counters are sized $clog2 of their field width plus 1, so there is no wrap-around aliasing.

Commit, in the cycle after the STOP sample:
- The staging registers hold the received buffer and ID fields. The output registers are event_id_o and event_id_buffer_o.
- Good frame (stop = 0 and, if PARITY_EN, the XOR of the buffer bits, ID bits and parity bit = 0):
  - event_id_o and event_id_buffer_o load from the staging registers.
  - event_id_wr_o = 1.
  - digitize_o[buf] = 1.
  - All three are for exactly one cycle, and they occur in the same cycle.
- Stop = 1: frame_err_o pulses. Outputs keep their previous values. No digitize.
- Stop = 0 with bad parity: parity_err_o pulses. Outputs are unchanged. No digitize.
- If both errors apply, only frame_err_o pulses and the counter increments once.
- err_cnt_o increments by 1 per error and holds at all-ones.

RECOVER:
- Stays in RECOVER until cmd_sync = 0, then goes to IDLE.
- A line stuck high therefore never re-triggers.
- busy_o stays high in RECOVER.

Frame length: START_WAIT + CLKS_PER_BIT × (NBUF + NID + PARITY_EN + 1) clocks from the IDLE exit to the STOP sample.

Test Plan:
- Defaults, frame with buf = 2'b10, ID = 0xDEADBEEF, correct parity, stop 0 → event_id_o = 0xDEADBEEF, event_id_buffer_o = 2, digitize_o = 4'b0100 for 1 cycle; event_id_wr_o pulses 1 + 6 + 8×36 cycles after cmd_sync rises.
- Same frame with the parity bit flipped → parity_err_o pulses, err_cnt_o = 1, outputs retain their prior value, digitize_o stays 0.
- Stop bit = 1 → frame_err_o pulses; err_cnt_o increments; then cmd_i held high for 100 clocks → busy_o stays 1 and no new frame starts until cmd_i goes low.
- rst_n_i pulled low during the ID field → next cycle is IDLE, all outputs 0, no strobes; a following good frame decodes correctly.
- ERR_BITS = 2, 5 bad-parity frames → err_cnt_o reads 1, 2, 3, 3, 3.
- NBUF = 3, NID = 16, PARITY_EN = 0, CLKS_PER_BIT = 4: frame buf = 5, ID = 0x1234 → digitize_o = 8'b0010_0000, event_id_o = 0x1234.
